// File: rtl/trace_mem_ctrl_pkg.sv
// Shared sizing and state encoding for the debug trace buffer controller.
package DTB_PKG;

    localparam int TRB_DEPTH     = 8;
    localparam int TRB_WIDTH     = 32;
    localparam int TRB_ADDR_BITS = $clog2(TRB_DEPTH);

    typedef enum logic [1:0] {
        ST_ARMED = 2'd0,
        ST_POST  = 2'd1,
        ST_DONE  = 2'd2
    } trc_state_e;

endpackage

// File: rtl/trace_mem_ctrl_if.sv
// Request/grant bundle between the controller and its store/load arbiter.
interface trace_mem_ctrl_if;

    logic req_store;
    logic req_load;
    logic gnt_store;
    logic gnt_load;

    modport master (output req_store, output req_load, input gnt_store, input gnt_load);
    modport slave  (input req_store, input req_load, output gnt_store, output gnt_load);

endinterface

// File: rtl/trace_mem_ctrl_arb.sv
// Two-way round-robin arbiter: store and load contend for the single memory port.
module trace_mem_arb (
    input  logic             clk,
    input  logic             rst,
    trace_mem_ctrl_if.slave  arb
);

    logic [1:0] gnt;
    // Set when store won the last conflict, so load is favoured next time.
    logic       last_store_q;
    logic       last_store_d;

    always_comb begin
        gnt          = {arb.req_load, arb.req_store};
        last_store_d = last_store_q;
        if (arb.req_store && arb.req_load) begin
            gnt          = last_store_q ? 2'b10 : 2'b01;
            last_store_d = !last_store_q;
        end
    end

    assign arb.gnt_store = gnt[0];
    assign arb.gnt_load  = gnt[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            last_store_q <= 1'b0;
        end else begin
            last_store_q <= last_store_d;
        end
    end

endmodule

// File: rtl/trace_mem_ctrl.sv
// Trace buffer controller: ring capture with trigger/post-delay, or plain FIFO
// streaming, over a single-port memory with one-cycle read latency.
module trace_mem_ctrl #(
    parameter  int TRB_DEPTH     = DTB_PKG::TRB_DEPTH,
    parameter  int TRB_WIDTH     = DTB_PKG::TRB_WIDTH,
    localparam int TRB_ADDR_BITS = $clog2(TRB_DEPTH),
    localparam int POS_BITS      = $clog2(TRB_WIDTH)
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic                     MODE_I,
    input  logic [TRB_ADDR_BITS-1:0] TRG_DELAY_I,
    input  logic                     STORE_I,
    input  logic [TRB_WIDTH-1:0]     DATA_I,
    output logic                     STORE_PERM_O,
    input  logic                     LOAD_REQUEST_I,
    output logic                     LOAD_GRANT_O,
    output logic [TRB_WIDTH-1:0]     DATA_O,
    input  logic                     TRG_EVENT_I,
    input  logic [POS_BITS-1:0]      EVENT_POS_I,
    output logic                     TRG_DELAYED_O,
    output logic [TRB_ADDR_BITS-1:0] TRG_ADDR_O,
    output logic [POS_BITS-1:0]      TRG_BIT_O,
    output logic [TRB_ADDR_BITS-1:0] MEM_ADDR_O,
    output logic                     MEM_WE_O,
    output logic [TRB_WIDTH-1:0]     MEM_WDATA_O,
    input  logic [TRB_WIDTH-1:0]     MEM_RDATA_I
);

    import DTB_PKG::*;

    localparam logic [TRB_ADDR_BITS:0] FULL_CNT = (TRB_ADDR_BITS+1)'(TRB_DEPTH);

    logic                     mode_q;
    logic [TRB_ADDR_BITS-1:0] dly_q;
    trc_state_e               state_q, state_d;
    logic [TRB_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [TRB_ADDR_BITS-1:0] post_q, post_d, trg_addr_q, trg_addr_d;
    logic [TRB_ADDR_BITS-1:0] post_inc;
    logic [POS_BITS-1:0]      trg_bit_q, trg_bit_d;
    logic [TRB_ADDR_BITS:0]   count_q, count_d;
    logic                     pend_q, pend_d;
    logic [TRB_WIDTH-1:0]     data_q, data_d;
    logic                     full, empty, store_perm, do_store, do_load;
    logic [TRB_ADDR_BITS-1:0] mem_addr;

    trace_mem_ctrl_if arb_bus ();

    trace_mem_arb u_arb (
        .clk (CLK_I),
        .rst (RST_I),
        .arb (arb_bus)
    );

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // Load request is not masked by a pending read so that a blocked cycle still
    // counts as a conflict; this keeps store/load strictly alternating under load.
    assign arb_bus.req_store = mode_q && STORE_I && !full;
    assign arb_bus.req_load  = mode_q && LOAD_REQUEST_I && !empty;

    always_comb begin
        if (mode_q) begin
            store_perm = arb_bus.gnt_store || (pend_q && arb_bus.req_store);
            do_load    = arb_bus.gnt_load && !pend_q;
        end else begin
            store_perm = (state_q != ST_DONE);
            do_load    = (state_q == ST_DONE) && LOAD_REQUEST_I && !empty && !pend_q;
        end
        do_store = STORE_I && store_perm;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        post_d     = post_q;
        post_inc   = post_q + 1'b1;
        trg_addr_d = trg_addr_q;
        trg_bit_d  = trg_bit_q;
        state_d    = state_q;
        count_d    = count_q;
        pend_d     = do_load;
        data_d     = pend_q ? MEM_RDATA_I : data_q;

        if (do_store) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_load)  rd_ptr_d = rd_ptr_q + 1'b1;

        // Count saturates on ring overwrite; a store and a grant in one cycle cancel.
        case ({do_store && !full, pend_q})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (!mode_q) begin
            case (state_q)
                ST_ARMED: if (do_store && TRG_EVENT_I) begin
                    trg_addr_d = wr_ptr_q;
                    trg_bit_d  = EVENT_POS_I;
                    post_d     = '0;
                    state_d    = (dly_q == '0) ? ST_DONE : ST_POST;
                end
                ST_POST: if (do_store) begin
                    post_d = post_inc;
                    if (post_inc == dly_q) state_d = ST_DONE;
                end
                default: state_d = state_q;
            endcase
            if (state_d == ST_DONE && state_q != ST_DONE) begin
                rd_ptr_d = (count_d == FULL_CNT) ? wr_ptr_d : '0;
            end
        end
    end

    always_comb begin
        mem_addr = '0;
        if (do_store)     mem_addr = wr_ptr_q;
        else if (do_load) mem_addr = rd_ptr_q;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            mode_q     <= MODE_I;
            dly_q      <= TRG_DELAY_I;
            state_q    <= ST_ARMED;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            post_q     <= '0;
            trg_addr_q <= '0;
            trg_bit_q  <= '0;
            count_q    <= '0;
            pend_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            post_q     <= post_d;
            trg_addr_q <= trg_addr_d;
            trg_bit_q  <= trg_bit_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            data_q     <= data_d;
        end
    end

    // Every output is forced low while reset is asserted, including in-flight reads.
    assign STORE_PERM_O  = !RST_I && store_perm;
    assign MEM_WE_O      = !RST_I && do_store;
    assign MEM_ADDR_O    = RST_I ? '0 : mem_addr;
    assign MEM_WDATA_O   = (!RST_I && do_store) ? DATA_I : '0;
    assign LOAD_GRANT_O  = !RST_I && pend_q;
    assign DATA_O        = RST_I ? '0 : (pend_q ? MEM_RDATA_I : data_q);
    assign TRG_DELAYED_O = !RST_I && (mode_q ? (!empty || pend_q) : (state_q == ST_DONE));
    assign TRG_ADDR_O    = RST_I ? '0 : trg_addr_q;
    assign TRG_BIT_O     = RST_I ? '0 : trg_bit_q;

endmodule

// File: tb/tb_trace_mem_ctrl.sv
// Directed bench for trace_mem_ctrl (depth 8, width 32) with a behavioural memory.
module tb_trace_mem_ctrl;

    localparam int W = 32;
    localparam int A = 3;
    localparam int P = 5;

    logic          CLK_I = 1'b0;
    logic          RST_I;
    logic          MODE_I;
    logic [A-1:0]  TRG_DELAY_I;
    logic          STORE_I;
    logic [W-1:0]  DATA_I;
    logic          STORE_PERM_O;
    logic          LOAD_REQUEST_I;
    logic          LOAD_GRANT_O;
    logic [W-1:0]  DATA_O;
    logic          TRG_EVENT_I;
    logic [P-1:0]  EVENT_POS_I;
    logic          TRG_DELAYED_O;
    logic [A-1:0]  TRG_ADDR_O;
    logic [P-1:0]  TRG_BIT_O;
    logic [A-1:0]  MEM_ADDR_O;
    logic          MEM_WE_O;
    logic [W-1:0]  MEM_WDATA_O;
    logic [W-1:0]  MEM_RDATA_I;

    logic [W-1:0]  mem [8];
    logic [W-1:0]  exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;

    trace_mem_ctrl #(.TRB_DEPTH(8), .TRB_WIDTH(32)) dut (
        .CLK_I          (CLK_I),
        .RST_I          (RST_I),
        .MODE_I         (MODE_I),
        .TRG_DELAY_I    (TRG_DELAY_I),
        .STORE_I        (STORE_I),
        .DATA_I         (DATA_I),
        .STORE_PERM_O   (STORE_PERM_O),
        .LOAD_REQUEST_I (LOAD_REQUEST_I),
        .LOAD_GRANT_O   (LOAD_GRANT_O),
        .DATA_O         (DATA_O),
        .TRG_EVENT_I    (TRG_EVENT_I),
        .EVENT_POS_I    (EVENT_POS_I),
        .TRG_DELAYED_O  (TRG_DELAYED_O),
        .TRG_ADDR_O     (TRG_ADDR_O),
        .TRG_BIT_O      (TRG_BIT_O),
        .MEM_ADDR_O     (MEM_ADDR_O),
        .MEM_WE_O       (MEM_WE_O),
        .MEM_WDATA_O    (MEM_WDATA_O),
        .MEM_RDATA_I    (MEM_RDATA_I)
    );

    // clock / reset and memory model
    always #5 CLK_I = ~CLK_I;

    always @(posedge CLK_I) begin
        if (MEM_WE_O) mem[MEM_ADDR_O] <= MEM_WDATA_O;
        MEM_RDATA_I <= mem[MEM_ADDR_O];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    // scoreboard
    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_vec({tag, "_ctl"}, {STORE_PERM_O, LOAD_GRANT_O, TRG_DELAYED_O, MEM_WE_O}, 64'd0);
        check_vec({tag, "_addr"}, {TRG_ADDR_O, TRG_BIT_O, MEM_ADDR_O}, 64'd0);
        check_vec({tag, "_data"}, {DATA_O, MEM_WDATA_O}, 64'd0);
    endtask

    task automatic do_reset(input logic m, input logic [A-1:0] d);
        RST_I = 1'b1; MODE_I = m; TRG_DELAY_I = d;
        STORE_I = 1'b1; DATA_I = 32'hA5A5_5A5A; LOAD_REQUEST_I = 1'b1;
        TRG_EVENT_I = 1'b1; EVENT_POS_I = 5'd9;
        tick(); tick(); #3;
        check_all_zero("rst");
        tick();
        RST_I = 1'b0; STORE_I = 1'b0; DATA_I = '0; LOAD_REQUEST_I = 1'b0;
        TRG_EVENT_I = 1'b0; EVENT_POS_I = '0;
    endtask

    task automatic store_word(input string tag, input logic [W-1:0] d, input logic trg,
                              input logic [P-1:0] pos, input logic [A-1:0] exp_addr);
        STORE_I = 1'b1; DATA_I = d; TRG_EVENT_I = trg; EVENT_POS_I = pos;
        #3;
        check_vec({tag, "_st"}, {STORE_PERM_O, MEM_WE_O, MEM_ADDR_O, MEM_WDATA_O},
                  {1'b1, 1'b1, exp_addr, d});
        tick();
        STORE_I = 1'b0; TRG_EVENT_I = 1'b0;
    endtask

    task automatic read_word(input string tag, input logic exp_gnt, input logic [A-1:0] exp_addr,
                             input logic [W-1:0] exp_data);
        LOAD_REQUEST_I = 1'b1;
        #3;
        check_vec({tag, "_iss"}, {MEM_WE_O, MEM_ADDR_O}, {1'b0, exp_addr});
        tick();
        LOAD_REQUEST_I = 1'b0;
        #3;
        check_vec({tag, "_gnt"}, LOAD_GRANT_O, exp_gnt);
        if (exp_gnt) check_vec({tag, "_dat"}, DATA_O, exp_data);
        tick();
    endtask

    initial begin
        logic [4:0]   we_pat;
        logic [4:0]   gnt_pat;
        logic [A-1:0] exp_addr;

        RST_I = 1'b1; MODE_I = 1'b0; TRG_DELAY_I = '0; STORE_I = 1'b0; DATA_I = '0;
        LOAD_REQUEST_I = 1'b0; TRG_EVENT_I = 1'b0; EVENT_POS_I = '0;

        // trace, delay 2, trigger on store 3 at bit 7
        do_reset(1'b0, 3'd2);
        for (int i = 1; i <= 5; i++) begin
            if (i == 5) begin
                #3;
                check_vec("t2_pre_done", TRG_DELAYED_O, 1'b0);
                tick();
            end
            store_word("t2", 32'h100 + i, (i == 3), 5'd7, A'(i - 1));
        end
        #3;
        check_vec("t2_done", {TRG_DELAYED_O, STORE_PERM_O, TRG_ADDR_O, TRG_BIT_O},
                  {1'b1, 1'b0, 3'd2, 5'd7});
        STORE_I = 1'b1; DATA_I = 32'hDEAD;
        #1;
        check_vec("t2_no_we", {MEM_WE_O, MEM_WDATA_O}, 64'd0);
        tick();
        STORE_I = 1'b0;

        // trace ring wrap: words 0..10, trigger on 8 (second trigger on 9 ignored)
        do_reset(1'b0, 3'd2);
        exp_q.delete();
        for (int k = 0; k <= 10; k++) begin
            store_word("t3", 32'(k), (k == 8 || k == 9), (k == 9) ? 5'd20 : 5'd3, A'(k));
        end
        for (int k = 3; k <= 10; k++) exp_q.push_back(32'(k));
        #3;
        check_vec("t3_trg", {TRG_DELAYED_O, TRG_ADDR_O, TRG_BIT_O}, {1'b1, 3'd0, 5'd3});
        tick();
        for (int r = 0; r < 8; r++) begin
            read_word("t3_rd", 1'b1, A'(r + 3), exp_q.pop_front());
        end
        read_word("t3_rd9", 1'b0, 3'd0, '0);
        #3;
        check_vec("t3_hold", DATA_O, 32'd10);
        tick();

        // trace, zero delay, trigger on first store
        do_reset(1'b0, 3'd0);
        store_word("t4", 32'hCAFE_F00D, 1'b1, 5'd31, 3'd0);
        #3;
        check_vec("t4_done", {TRG_DELAYED_O, STORE_PERM_O, TRG_ADDR_O, TRG_BIT_O},
                  {1'b1, 1'b0, 3'd0, 5'd31});
        tick();
        read_word("t4_rd", 1'b1, 3'd0, 32'hCAFE_F00D);
        read_word("t4_rd2", 1'b0, 3'd0, '0);

        // stream: fill to full, mode change after reset is ignored
        do_reset(1'b1, 3'd5);
        MODE_I = 1'b0; TRG_DELAY_I = 3'd0;
        #3;
        check_vec("t5_empty", TRG_DELAYED_O, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) store_word("t5", 32'h200 + i, 1'b0, 5'd0, A'(i));
        STORE_I = 1'b1; DATA_I = 32'h2FF;
        #3;
        check_vec("t5_full", {STORE_PERM_O, MEM_WE_O, TRG_DELAYED_O}, 3'b001);
        tick();
        LOAD_REQUEST_I = 1'b1;
        #3;
        check_vec("t5_iss", {MEM_WE_O, MEM_ADDR_O, STORE_PERM_O}, 5'd0);
        tick();
        LOAD_REQUEST_I = 1'b0;
        #3;
        check_vec("t5_gnt", {LOAD_GRANT_O, DATA_O, STORE_PERM_O}, {1'b1, 32'h200, 1'b0});
        tick();
        #3;
        check_vec("t5_refill", {STORE_PERM_O, MEM_WE_O, MEM_ADDR_O, MEM_WDATA_O},
                  {1'b1, 1'b1, 3'd0, 32'h2FF});
        tick();
        #3;
        check_vec("t5_full2", STORE_PERM_O, 1'b0);
        STORE_I = 1'b0;
        tick();

        // stream: store and load contending from count 4
        do_reset(1'b1, 3'd0);
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            store_word("t6", 32'h300 + i, 1'b0, 5'd0, A'(i));
            exp_q.push_back(32'h300 + i);
        end
        we_pat = 5'b10101;
        gnt_pat = 5'b10100;
        STORE_I = 1'b1; LOAD_REQUEST_I = 1'b1;
        for (int c = 0; c < 5; c++) begin
            DATA_I = 32'h400 + c;
            #3;
            exp_addr = (c % 2 == 0) ? A'(4 + c / 2) : A'(c / 2);
            check_vec("t6_bus", {MEM_WE_O, MEM_ADDR_O}, {we_pat[c], exp_addr});
            check_vec("t6_gnt", LOAD_GRANT_O, gnt_pat[c]);
            if (gnt_pat[c]) check_vec("t6_dat", DATA_O, exp_q.pop_front());
            tick();
        end
        STORE_I = 1'b0; LOAD_REQUEST_I = 1'b0;

        // stream: reset lands on the grant cycle of an issued read
        LOAD_REQUEST_I = 1'b1;
        #3;
        check_vec("t7_iss", {MEM_WE_O, MEM_ADDR_O}, {1'b0, 3'd2});
        tick();
        LOAD_REQUEST_I = 1'b0; RST_I = 1'b1; MODE_I = 1'b1;
        #3;
        check_all_zero("t7_rst");
        tick();
        #3;
        check_vec("t7_nognt", LOAD_GRANT_O, 1'b0);
        tick();
        RST_I = 1'b0;
        #3;
        check_vec("t7_after", {TRG_DELAYED_O, LOAD_GRANT_O, DATA_O}, 64'd0);
        tick();

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/trace_mem_ctrl.md
TRACE_MEM_CTRL -- requirements
Module: trace_mem_ctrl

Interface
REQ-001 The block SHALL have parameter TRB_DEPTH, default from DTB_PKG, meaning number of TRB_WIDTH-bit words in trace memory (power of two, >=4).
REQ-002 Ports SHALL be (name direction width meaning):
  CLK_I  in  1  single clock
  RST_I  in  1  reset, synchronous, active-high
  MODE_I  in  1  0 = trace (ring + trigger), 1 = stream (FIFO)
  TRG_DELAY_I  in  TRB_ADDR_BITS  words stored after trigger word before capture stops
  STORE_I  in  1  tracer holds word for storage (level)
  DATA_I  in  TRB_WIDTH  word from tracer
  STORE_PERM_O  out  1  store accepted this cycle
  LOAD_REQUEST_I  in  1  tracer requests next word (level)
  LOAD_GRANT_O  out  1  DATA_O valid, one-cycle pulse
  DATA_O  out  TRB_WIDTH  word to tracer
  TRG_EVENT_I  in  1  trigger seen in current stored word
  EVENT_POS_I  in  $clog2(TRB_WIDTH)  bit position of trigger in that word
  TRG_DELAYED_O  out  1  post-trigger capture complete
  TRG_ADDR_O  out  TRB_ADDR_BITS  address of trigger word
  TRG_BIT_O  out  $clog2(TRB_WIDTH)  latched EVENT_POS_I
  MEM_ADDR_O  out  TRB_ADDR_BITS  memory address
  MEM_WE_O  out  1  memory write strobe
  MEM_WDATA_O  out  TRB_WIDTH  memory write data
  MEM_RDATA_I  in  TRB_WIDTH  memory read data, 1-cycle latency

Function
REQ-003 Memory SHALL be single-port: at most one write or one read issued per cycle.
REQ-004 Write pointer wr_ptr, read pointer rd_ptr SHALL be TRB_ADDR_BITS wide and wrap modulo TRB_DEPTH; fill count SHALL be TRB_ADDR_BITS+1 bits, range 0..TRB_DEPTH.
REQ-005 Store acceptance: STORE_PERM_O combinational; when STORE_I & STORE_PERM_O, MEM_WE_O=1, MEM_ADDR_O=wr_ptr, MEM_WDATA_O=DATA_I, wr_ptr+1 next cycle.
REQ-006 Load issue: MEM_ADDR_O=rd_ptr, MEM_WE_O=0; next cycle LOAD_GRANT_O=1, DATA_O=MEM_RDATA_I, rd_ptr+1; no new load issued in the issue or grant cycle.
REQ-007 DATA_O SHALL hold last granted word between grants.
REQ-008 Trace-mode FSM states: ARMED, POST, DONE.
REQ-009 ARMED: every store accepted (ring overwrite, count saturates at TRB_DEPTH); loads never issued; on accepted store with TRG_EVENT_I=1 latch TRG_ADDR_O=wr_ptr, TRG_BIT_O=EVENT_POS_I, post counter=0, go POST (or DONE if TRG_DELAY_I=0).
REQ-010 POST: stores accepted; each increments post counter; store making counter equal TRG_DELAY_I goes DONE; TRG_EVENT_I ignored.
REQ-011 DONE: STORE_PERM_O=0, TRG_DELAYED_O=1; rd_ptr set on entry to oldest valid word (wr_ptr if count=TRB_DEPTH, else 0); loads served while count>0, each decrementing count; count=0 -> LOAD_REQUEST_I ignored.
REQ-012 Stream mode: FSM unused, TRG_DELAYED_O=1 iff count>0 or grant pending; store allowed iff count<TRB_DEPTH; load allowed iff count>0.
REQ-013 Stream arbitration when store and load both allowed in same cycle: round-robin, winner toggles after each conflict, store wins first conflict after reset.
REQ-014 Store and grant completing in same cycle SHALL leave count unchanged.
REQ-015 MODE_I and TRG_DELAY_I SHALL be sampled only under reset; changes otherwise ignored.

Reset
REQ-016 During RST_I: wr_ptr, rd_ptr, count, post counter=0; FSM=ARMED; arbiter favours store; all outputs 0 (STORE_PERM_O, LOAD_GRANT_O, DATA_O, TRG_DELAYED_O, TRG_ADDR_O, TRG_BIT_O, MEM_WE_O, MEM_ADDR_O, MEM_WDATA_O).
REQ-017 Reset mid-operation SHALL discard any pending load (no grant follows) and take effect next edge.

Structure
REQ-018 TRB_DEPTH, TRB_ADDR_BITS=$clog2(TRB_DEPTH) and FSM state enum SHALL live in DTB_PKG.
REQ-019 Round-robin arbiter SHALL be sub-module trace_mem_arb (two requesters, grant vector, last-winner register).

Verification (TRB_DEPTH=8)
REQ-020 Trace, TRG_DELAY_I=2, 5 stores, trigger on store 3, EVENT_POS_I=7 -> TRG_ADDR_O=2, TRG_BIT_O=7, TRG_DELAYED_O=1 after store 5, STORE_PERM_O=0 after.
REQ-021 Trace, 11 stores words 0..10, trigger on word 8, delay 2 -> readout of 8 words returns 3..10, 9th request no grant.
REQ-022 Stream, 8 stores without loads -> STORE_PERM_O=0 with STORE_I held; one grant -> store accepted next cycle, count 8.
REQ-023 Stream, STORE_I and LOAD_REQUEST_I both held, count=4 -> MEM_WE_O alternates 1,0,1,0 starting with store; each load granted exactly 1 cycle after issue.
REQ-024 Stream, read issued then RST_I=1 next cycle -> LOAD_GRANT_O stays 0, all outputs 0.
REQ-025 Trace, TRG_DELAY_I=0, trigger on first store -> DONE next cycle, one-word readout equals stored word.
